pipe_reg_em_hs: RTL and testbench

Parametrised EX/MEM pipeline stage for the vector core. It carries a LANES×DW ALU result and store-data vector plus the memory/writeback control bits from Execute to Memory. Unlike a plain enable-less register, it uses a valid/ready handshake with a one-entry skid buffer, so back-pressure from Memory stalls Execute without loss. It also supports a synchronous flush for branch redirect and counts stall cycles for performance monitoring.

---
 rtl/pipe_reg_em_hs.sv | 148 ++++++++++++++
 tb/tb_pipe_reg_em_hs.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_em_hs.sv
// EX/MEM pipeline register with valid/ready handshake and one-entry skid.
// Carries vector ALU result, store data and mem/wb control; counts stalls.
module pipe_reg_em_hs #(
    parameter int LANES = 16,
    parameter int DW    = 32,
    parameter int RAW   = 4,
    parameter int CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   ALUResultE,
    input  logic [LANES*DW-1:0]   WriteDataE,
    input  logic                  PCSrcE,
    input  logic                  RegWriteE,
    input  logic                  MemtoRegE,
    input  logic                  MemWriteE,
    input  logic                  v_s_e,
    input  logic [RAW-1:0]        WA3E,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   ALUResultM,
    output logic [LANES*DW-1:0]   WriteDataM,
    output logic                  MemtoRegM,
    output logic                  v_s_m,
    output logic                  PCSrcM,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [RAW-1:0]        WA3M,
    output logic [CNT_W-1:0]      stall_cnt,
    input  logic                  cnt_clr
);

    typedef struct packed {
        logic [LANES*DW-1:0] alu;
        logic [LANES*DW-1:0] wd;
        logic                pcsrc;
        logic                regwrite;
        logic                memtoreg;
        logic                memwrite;
        logic                vs;
        logic [RAW-1:0]      wa3;
    } ent_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_e;

    state_e           state_q, state_d;
    ent_t             main_q, main_d;
    ent_t             skid_q, skid_d;
    ent_t             in_ent;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc;
    logic             con;

    assign in_ent = '{
        alu:      ALUResultE,
        wd:       WriteDataE,
        pcsrc:    PCSrcE,
        regwrite: RegWriteE,
        memtoreg: MemtoRegE,
        memwrite: MemWriteE,
        vs:       v_s_e,
        wa3:      WA3E
    };

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign acc       = in_valid & in_ready;
    assign con       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Valid bits drop; data registers keep their contents.
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (acc) begin
                        main_d  = in_ent;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (acc && con) begin
                        main_d = in_ent;
                    end else if (acc) begin
                        skid_d  = in_ent;
                        state_d = S_FULL;
                    end else if (con) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (con) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ALUResultM = main_q.alu;
    assign WriteDataM = main_q.wd;
    assign MemtoRegM  = main_q.memtoreg;
    assign v_s_m      = main_q.vs;
    assign WA3M       = main_q.wa3;
    // Bubbles must never write or redirect.
    assign PCSrcM     = main_q.pcsrc & out_valid;
    assign RegWriteM  = main_q.regwrite & out_valid;
    assign MemWriteM  = main_q.memwrite & out_valid;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_reg_em_hs.sv
// Directed bench for pipe_reg_em_hs with a FIFO scoreboard and stall models.
// A second instance with a 4-bit counter covers saturation.
module tb_pipe_reg_em_hs;

    localparam int LANES = 16;
    localparam int DW    = 32;
    localparam int RAW   = 4;
    localparam int W     = LANES * DW;

    typedef struct {
        logic [W-1:0]   alu;
        logic [W-1:0]   wd;
        logic           pc;
        logic           rw;
        logic           m2r;
        logic           mw;
        logic           vs;
        logic [RAW-1:0] wa;
    } ent_t;

    logic           CLK = 1'b0;
    logic           RST;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   ALUResultE;
    logic [W-1:0]   WriteDataE;
    logic           PCSrcE, RegWriteE, MemtoRegE, MemWriteE, v_s_e;
    logic [RAW-1:0] WA3E;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   ALUResultM, WriteDataM;
    logic           MemtoRegM, v_s_m, PCSrcM, RegWriteM, MemWriteM;
    logic [RAW-1:0] WA3M;
    logic [15:0]    stall_cnt;
    logic           cnt_clr;

    logic           in_ready_s, out_valid_s;
    logic [W-1:0]   alu_s, wd_s;
    logic           m2r_s, vs_s, pc_s, rw_s, mw_s;
    logic [RAW-1:0] wa_s;
    logic [3:0]     stall_cnt_s;

    ent_t sb[$];
    int   c16, c4;
    int   ncmp, nfail;
    bit   last_acc;
    bit   done;

    always #5 CLK = ~CLK;

    pipe_reg_em_hs #(.LANES(LANES), .DW(DW), .RAW(RAW), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .v_s_e(v_s_e), .WA3E(WA3E),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .MemtoRegM(MemtoRegM), .v_s_m(v_s_m), .PCSrcM(PCSrcM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .WA3M(WA3M),
        .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
    );

    pipe_reg_em_hs #(.LANES(LANES), .DW(DW), .RAW(RAW), .CNT_W(4)) dut_s (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .v_s_e(v_s_e), .WA3E(WA3E),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .ALUResultM(alu_s), .WriteDataM(wd_s),
        .MemtoRegM(m2r_s), .v_s_m(vs_s), .PCSrcM(pc_s),
        .RegWriteM(rw_s), .MemWriteM(mw_s), .WA3M(wa_s),
        .stall_cnt(stall_cnt_s), .cnt_clr(cnt_clr)
    );

    task automatic chk(input string tag, input logic [W-1:0] o,
                       input logic [W-1:0] e);
        ncmp++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic set_in(input int i);
        for (int k = 0; k < LANES; k++) begin
            ALUResultE[k*DW +: DW] = DW'(i * 16 + k);
            WriteDataE[k*DW +: DW] = ~DW'(i * 16 + k);
        end
        PCSrcE    = i[0];
        RegWriteE = i[1];
        MemtoRegE = i[2];
        MemWriteE = ~i[0];
        v_s_e     = ~i[1];
        WA3E      = RAW'(i + 3);
    endtask

    function automatic ent_t cur_in();
        ent_t e;
        e.alu = ALUResultE;
        e.wd  = WriteDataE;
        e.pc  = PCSrcE;
        e.rw  = RegWriteE;
        e.m2r = MemtoRegE;
        e.mw  = MemWriteE;
        e.vs  = v_s_e;
        e.wa  = WA3E;
        return e;
    endfunction

    task automatic check_state();
        chk("out_valid", out_valid, sb.size() > 0);
        chk("in_ready", in_ready, sb.size() < 2);
        chk("stall_cnt", stall_cnt, c16);
        chk("stall_cnt4", stall_cnt_s, c4);
        if (sb.size() > 0) begin
            chk("ALUResultM", ALUResultM, sb[0].alu);
            chk("WriteDataM", WriteDataM, sb[0].wd);
            chk("PCSrcM", PCSrcM, sb[0].pc);
            chk("RegWriteM", RegWriteM, sb[0].rw);
            chk("MemtoRegM", MemtoRegM, sb[0].m2r);
            chk("MemWriteM", MemWriteM, sb[0].mw);
            chk("v_s_m", v_s_m, sb[0].vs);
            chk("WA3M", WA3M, sb[0].wa);
        end else begin
            chk("PCSrcM_gated", PCSrcM, 0);
            chk("RegWriteM_gated", RegWriteM, 0);
            chk("MemWriteM_gated", MemWriteM, 0);
        end
    endtask

    // One clock: update models from the inputs in force, then check.
    task automatic cyc();
        bit acc, con;
        acc = in_valid && (sb.size() < 2);
        con = (sb.size() > 0) && out_ready;
        if (cnt_clr) begin
            c16 = 0;
            c4  = 0;
        end else if (sb.size() > 0 && !out_ready) begin
            if (c16 != 65535) c16++;
            if (c4 != 15) c4++;
        end
        if (flush) begin
            sb.delete();
        end else begin
            if (con) void'(sb.pop_front());
            if (acc) sb.push_back(cur_in());
        end
        last_acc = acc;
        @(posedge CLK);
        #1;
        check_state();
    endtask

    task automatic hold_until_acc(input string tag);
        done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            cyc();
            if (last_acc) done = 1;
        end
        chk(tag, done, 1);
        in_valid = 0;
    endtask

    initial begin
        ncmp = 0; nfail = 0; c16 = 0; c4 = 0;
        RST = 1; flush = 0; in_valid = 0; out_ready = 0; cnt_clr = 0;
        set_in(0);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ALUResultM", ALUResultM, 0);
        chk("rst_WA3M", WA3M, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        @(posedge CLK);
        #1;
        RST = 0;

        // Streaming, 8 back-to-back entries
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            set_in(i);
            in_valid = 1;
            cyc();
            chk("stream_valid", out_valid, 1);
        end
        in_valid = 0;
        cyc();
        cyc();
        chk("stream_stall0", stall_cnt, 0);

        // Back-pressure: A, B, C
        set_in(20); in_valid = 1; out_ready = 1;
        cyc();
        set_in(21); out_ready = 0;
        cyc();
        set_in(22);
        for (int n = 0; n < 4; n++) begin
            cyc();
            chk("bp_in_ready", in_ready, 0);
        end
        chk("bp_stall5", stall_cnt, 5);
        out_ready = 1;
        hold_until_acc("bp_c_accept");
        cyc();
        cyc();
        chk("bp_drained", out_valid, 0);

        // Flush with FULL and C presented
        out_ready = 0;
        set_in(30); in_valid = 1;
        cyc();
        set_in(31);
        cyc();
        set_in(32); flush = 1;
        cyc();
        flush = 0; in_valid = 0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_regwrite", RegWriteM, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1;
        for (int n = 0; n < 3; n++) cyc();

        // Saturation and clear
        cnt_clr = 1;
        cyc();
        cnt_clr = 0;
        out_ready = 0;
        set_in(40); in_valid = 1;
        cyc();
        in_valid = 0;
        for (int n = 0; n < 20; n++) cyc();
        chk("sat_cnt4", stall_cnt_s, 15);
        chk("sat_cnt16", stall_cnt, 20);
        cnt_clr = 1;
        cyc();
        chk("clr_cnt", stall_cnt, 0);
        cnt_clr = 0;
        cyc();
        chk("clr_reinc", stall_cnt_s, 1);
        out_ready = 1;
        cyc();

        // Gating after consume
        set_in(50);
        RegWriteE = 1; MemWriteE = 1; PCSrcE = 1; WA3E = 4'hA;
        in_valid = 1;
        cyc();
        in_valid = 0;
        cyc();
        chk("gate_regwrite", RegWriteM, 0);
        chk("gate_memwrite", MemWriteM, 0);
        chk("gate_wa3_held", WA3M, 4'hA);

        // Reset mid-run with FULL occupancy
        out_ready = 0;
        set_in(60); in_valid = 1;
        cyc();
        set_in(61);
        cyc();
        in_valid = 0;
        chk("pre_rst_full", in_ready, 0);
        RST = 1;
        #1;
        sb.delete(); c16 = 0; c4 = 0;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_ALUResultM", ALUResultM, 0);
        chk("mrst_stall_cnt", stall_cnt, 0);
        @(posedge CLK);
        #1;
        RST = 0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
